// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-timer round controller.
// The LFSR step lives here so the generator and its seed stay defined together.
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        TIME  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam int          MAX_RT_MS = 9999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Galois mask for x^16 + x^14 + x^13 + x^11, right-shifting form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        logic [15:0] nxt;
        nxt = {1'b0, q[15:1]};
        if (q[0]) begin
            nxt = nxt ^ LFSR_TAPS;
        end
        // An all-zero register would lock up; fall back to the seed instead.
        if (q == 16'h0000) begin
            nxt = LFSR_SEED;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR used to randomise the pre-cue delay.
// Loads the seed on reset and advances on every clock otherwise.
module lfsr16
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= LFSR_SEED;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/reaction_ctrl_fsm.sv
// Reaction-timer round controller: random pre-cue delay, cue LED, reaction
// measurement in ms, and the early-press hand-off to the error-wait counter.
module reaction_ctrl_fsm #(
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 12,
    parameter int MAX_RT_MS    = reaction_pkg::MAX_RT_MS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1ms,
    input  logic        start,
    input  logic        stop,
    input  logic        error_wait_done,
    output logic        error_wait,
    output logic        led_on,
    output logic [13:0] rt_ms,
    output logic        rt_valid,
    output logic        timeout,
    output logic [2:0]  state_o
);

    import reaction_pkg::*;

    localparam logic [12:0] MIN_DLY = 13'(MIN_DELAY_MS);
    localparam logic [13:0] RT_MAX  = 14'(MAX_RT_MS);
    localparam logic [13:0] RT_LAST = 14'(MAX_RT_MS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [12:0] dly_cnt;
    logic [12:0] dly_nxt;
    logic [12:0] dly_load;
    logic [13:0] rt_cnt;
    logic [13:0] rt_cnt_nxt;
    logic [13:0] rt_ms_nxt;
    logic        timeout_q;
    logic        timeout_nxt;
    logic [15:0] lfsr_q;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Only the low RAND_BITS of the LFSR feed the delay.
    assign lfsr_unused = ^lfsr_q;
    assign dly_load    = MIN_DLY + 13'(lfsr_q[RAND_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dly_cnt   <= '0;
            rt_cnt    <= '0;
            rt_ms     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            dly_cnt   <= dly_nxt;
            rt_cnt    <= rt_cnt_nxt;
            rt_ms     <= rt_ms_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        dly_nxt     = dly_cnt;
        rt_cnt_nxt  = rt_cnt;
        rt_ms_nxt   = rt_ms;
        timeout_nxt = timeout_q;

        case (state)
            IDLE: begin
                rt_cnt_nxt = '0;
                if (start) begin
                    state_nxt = WAIT;
                    dly_nxt   = dly_load;
                end
            end

            WAIT: begin
                // An early press beats delay expiry in the same cycle.
                if (stop) begin
                    state_nxt = ERROR;
                end else if (dly_cnt == '0) begin
                    state_nxt  = TIME;
                    rt_cnt_nxt = '0;
                end else if (tick_1ms) begin
                    dly_nxt = dly_cnt - 13'd1;
                end
            end

            TIME: begin
                // The tick coinciding with the press is deliberately not counted.
                if (stop) begin
                    state_nxt   = DONE;
                    rt_ms_nxt   = rt_cnt;
                    timeout_nxt = 1'b0;
                end else if (tick_1ms) begin
                    if (rt_cnt >= RT_LAST) begin
                        state_nxt   = DONE;
                        rt_cnt_nxt  = RT_MAX;
                        rt_ms_nxt   = RT_MAX;
                        timeout_nxt = 1'b1;
                    end else begin
                        rt_cnt_nxt = rt_cnt + 14'd1;
                    end
                end
            end

            DONE: begin
                if (start) begin
                    state_nxt = WAIT;
                    dly_nxt   = dly_load;
                end
            end

            ERROR: begin
                if (error_wait_done) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode the state register only, so inputs never reach them combinationally.
    assign led_on     = (state == TIME);
    assign rt_valid   = (state == DONE);
    assign error_wait = (state == ERROR);
    assign timeout    = (state == DONE) && timeout_q;
    assign state_o    = state;

endmodule

// File: tb/tb_reaction_ctrl_fsm.sv
// Directed bench for reaction_ctrl_fsm with a scaled 1 ms tick (every 4 clocks),
// a 4..7 tick pre-cue delay and a 20 ms reaction ceiling.
module tb_reaction_ctrl_fsm;

    import reaction_pkg::*;

    localparam int MIN_DLY = 4;
    localparam int RBITS   = 2;
    localparam int MAX_RT  = 20;

    logic        clk             = 1'b0;
    logic        reset           = 1'b1;
    logic        tick_1ms        = 1'b0;
    logic        start           = 1'b0;
    logic        stop            = 1'b0;
    logic        error_wait_done = 1'b0;
    logic        error_wait;
    logic        led_on;
    logic [13:0] rt_ms;
    logic        rt_valid;
    logic        timeout;
    logic [2:0]  state_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_ticks  = 0;
    logic [15:0] m        = LFSR_SEED;
    logic [15:0] m_pre    = LFSR_SEED;
    logic [13:0] exp_q[$];

    always #5 clk = ~clk;

    reaction_ctrl_fsm #(
        .MIN_DELAY_MS (MIN_DLY),
        .RAND_BITS    (RBITS),
        .MAX_RT_MS    (MAX_RT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tick_1ms        (tick_1ms),
        .start           (start),
        .stop            (stop),
        .error_wait_done (error_wait_done),
        .error_wait      (error_wait),
        .led_on          (led_on),
        .rt_ms           (rt_ms),
        .rt_valid        (rt_valid),
        .timeout         (timeout),
        .state_o         (state_o)
    );

    // Reference LFSR written from the polynomial x^16+x^14+x^13+x^11.
    function automatic logic [15:0] model_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later.
    task automatic step(input logic s, input logic p, input logic e);
        start           = s;
        stop            = p;
        error_wait_done = e;
        tick_1ms        = ((cyc % 4) == 3);
        if (tick_1ms) n_ticks++;
        m_pre = m;
        @(posedge clk);
        m = reset ? LFSR_SEED : model_next(m);
        cyc++;
        #1;
    endtask

    task automatic wait_led(output int ticks);
        int  t0;
        bit  ok;
        t0 = n_ticks;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (led_on) ok = 1'b1;
        end
        ticks = n_ticks - t0;
        if (!ok) check("led_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic run_ticks(input int k);
        int t0;
        t0 = n_ticks;
        for (int i = 0; i < 400 && (n_ticks - t0) < k; i++) begin
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    // Arm from IDLE/DONE and run up to the cue; checks the delay against the model.
    task automatic arm_to_led(input string tag);
        int d;
        int t;
        step(1'b1, 1'b0, 1'b0);
        d = MIN_DLY + int'(m_pre[RBITS-1:0]);
        check({tag, "_arm_state"}, state_o, WAIT);
        check({tag, "_arm_rt_valid"}, rt_valid, 1'b0);
        wait_led(t);
        check({tag, "_delay"}, t, d);
        check({tag, "_delay_range"}, (t >= MIN_DLY && t <= MIN_DLY + 3), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          n;
        int          tl;
        int          t;
        bit          led_seen;
        bit          ok;
        logic [13:0] exp_rt;

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("rst_state", state_o, IDLE);
        check("rst_led", led_on, 1'b0);
        check("rst_rt_ms", rt_ms, 14'd0);
        check("rst_rt_valid", rt_valid, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_error_wait", error_wait, 1'b0);
        reset = 1'b0;

        // Normal round, stop after 7 ticks
        arm_to_led("r1");
        check("r1_led", led_on, 1'b1);
        run_ticks(7);
        step(1'b0, 1'b1, 1'b0);
        check("r1_state", state_o, DONE);
        check("r1_rt_ms", rt_ms, 14'd7);
        check("r1_rt_valid", rt_valid, 1'b1);
        check("r1_timeout", timeout, 1'b0);
        check("r1_led_off", led_on, 1'b0);

        // Re-arm from DONE, then early press
        step(1'b1, 1'b0, 1'b0);
        check("rearm_state", state_o, WAIT);
        check("rearm_rt_valid", rt_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("early_state", state_o, ERROR);
        check("early_error_wait", error_wait, 1'b1);
        check("early_led", led_on, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(i[0], i[1], 1'b0);
        end
        check("hold_error_wait", error_wait, 1'b1);
        check("hold_state", state_o, ERROR);
        step(1'b0, 1'b0, 1'b1);
        check("ewd_state", state_o, IDLE);
        check("ewd_error_wait", error_wait, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("idle_ignores_stop_ewd", state_o, IDLE);

        // Stop on the delay-expiry cycle
        step(1'b1, 1'b0, 1'b0);
        d = MIN_DLY + int'(m_pre[RBITS-1:0]);
        n = n_ticks;
        led_seen = 1'b0;
        for (int i = 0; i < 200 && (n_ticks - n) < d; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (led_on) led_seen = 1'b1;
        end
        step(1'b0, 1'b1, 1'b0);
        if (led_on) led_seen = 1'b1;
        check("expiry_stop_state", state_o, ERROR);
        check("expiry_led_never", led_seen, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("expiry_back_idle", state_o, IDLE);

        // Stop coincident with a tick in TIME
        arm_to_led("r4");
        tl = n_ticks;
        run_ticks(3);
        while ((cyc % 4) != 3) step(1'b0, 1'b0, 1'b0);
        exp_rt = 14'(n_ticks - tl);
        step(1'b0, 1'b1, 1'b0);
        check("tick_stop_tick_seen", tick_1ms, 1'b1);
        check("tick_stop_state", state_o, DONE);
        check("tick_stop_rt_ms", rt_ms, exp_rt);
        check("tick_stop_rt_3", rt_ms, 14'd3);

        // Timeout at MAX_RT
        arm_to_led("r3");
        tl = n_ticks;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step(1'b0, 1'b0, 1'b0);
            if (rt_valid) ok = 1'b1;
        end
        check("to_reached", ok, 1'b1);
        check("to_ticks", n_ticks - tl, MAX_RT);
        check("to_state", state_o, DONE);
        check("to_rt_ms", rt_ms, 14'(MAX_RT));
        check("to_timeout", timeout, 1'b1);
        check("to_led_off", led_on, 1'b0);

        // Ten rounds from DONE; start in TIME ignored
        for (int r = 0; r < 10; r++) begin
            arm_to_led("r6");
            tl = n_ticks;
            step(1'b1, 1'b0, 1'b0);
            check("r6_start_in_time", state_o, TIME);
            check("r6_timeout_clear", timeout, 1'b0);
            run_ticks(r % 4 + 1);
            exp_q.push_back(14'(n_ticks - tl));
            step(1'b0, 1'b1, 1'b0);
            check("r6_state", state_o, DONE);
            if (exp_q.size() > 0) begin
                exp_rt = exp_q.pop_front();
                check("r6_rt_ms", rt_ms, exp_rt);
            end
        end

        // Reset in the middle of TIME
        arm_to_led("r5");
        run_ticks(2);
        check("r5_led_before", led_on, 1'b1);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("r5_state", state_o, IDLE);
        check("r5_led", led_on, 1'b0);
        check("r5_rt_ms", rt_ms, 14'd0);
        check("r5_rt_valid", rt_valid, 1'b0);
        check("r5_timeout", timeout, 1'b0);
        check("r5_error_wait", error_wait, 1'b0);
        check("r5_lfsr", dut.u_lfsr.q, LFSR_SEED);

        // One more round to confirm the generator restarted from the seed
        arm_to_led("r7");
        run_ticks(5);
        step(1'b0, 1'b1, 1'b0);
        check("r7_rt_ms", rt_ms, 14'd5);
        t = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
